// File: rtl/game_irq_pkg.sv
// Shared constants for the game interrupt aggregator: register word
// addresses and field positions of the ACTIVE register.
package game_irq_pkg;

  localparam int unsigned MAX_IRQ          = 16;
  localparam int unsigned ACTIVE_VALID_BIT = 15;

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_EDGE    = 3'd2;
  localparam logic [2:0] ADDR_RAW     = 3'd3;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd4;
  localparam logic [2:0] ADDR_FORCE   = 3'd5;
  localparam logic [2:0] ADDR_MISSED  = 3'd6;

endpackage

// File: rtl/irq_src_cell.sv
// One interrupt source: optional two-flop synchronizer, rising-edge detect,
// and the pending bit. In edge mode, a set wins over a clear that lands in
// the same cycle. In level mode, the pending bit simply follows the input.
module irq_src_cell #(
  parameter bit SYNC_EN = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic irq_in,
  input  logic edge_mode,
  input  logic frc_set,
  input  logic clr_w1c,
  input  logic clr_ack,
  output logic sync_out,
  output logic pending,
  output logic missed
);

  logic s, s_d, rise, clr;

  generate
    if (SYNC_EN) begin : g_sync
      logic [1:0] sff;
      // two-flop synchronizer for asynchronous peripheral lines
      always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) sff <= '0;
        else          sff <= {sff[0], irq_in};
      assign s = sff[1];
    end else begin : g_nosync
      assign s = irq_in;
    end
  endgenerate

  // previous sample; reset to 0 so a line already high at reset release
  // produces one edge
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) s_d <= 1'b0;
    else          s_d <= s;

  assign rise     = s & ~s_d;
  assign clr      = clr_w1c | clr_ack;
  assign sync_out = s;
  assign missed   = edge_mode & rise & pending & ~clr;

  // pending bit: set-over-clear in edge mode, tracks input in level mode
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)            pending <= 1'b0;
    else if (!edge_mode)     pending <= s;
    else if (rise | frc_set) pending <= 1'b1;
    else if (clr)            pending <= 1'b0;

endmodule

// File: rtl/game_irq_ctrl.sv
// Avalon-MM interrupt aggregator. Holds MASK, EDGE_MODE and the saturating
// MISSED counter. It also contains the lowest-index-first priority encoder,
// the registered read mux and the combined irq output.
module game_irq_ctrl
  import game_irq_pkg::*;
#(
  parameter int unsigned NUM_IRQ    = 8,
  parameter bit          SYNC_EN    = 1'b1,
  parameter logic [15:0] EDGE_RESET = 16'hFFFF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  output logic               irq
);

  logic               wr;
  logic [NUM_IRQ-1:0] mask, edge_mode, pending, raw, missed_v, pm;
  logic [NUM_IRQ-1:0] w1c, frc;
  logic [15:0]        missed_cnt, rd_mux, rd_active;
  logic               act_valid;
  logic [3:0]         act_idx;
  logic               wr_ack;
  logic               unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wr_ack    = wr & (address == ADDR_ACTIVE);
  assign w1c       = (wr && address == ADDR_PENDING) ? writedata[NUM_IRQ-1:0] : '0;
  assign frc       = (wr && address == ADDR_FORCE)   ? writedata[NUM_IRQ-1:0] : '0;
  assign pm        = pending & mask;
  assign unused_wd = ^writedata;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_src
      irq_src_cell #(.SYNC_EN(SYNC_EN)) u_cell (
        .clk       (clk),
        .reset_n   (reset_n),
        .irq_in    (irq_in[gi]),
        .edge_mode (edge_mode[gi]),
        .frc_set   (frc[gi]),
        .clr_w1c   (w1c[gi]),
        .clr_ack   (wr_ack & act_valid & (act_idx == 4'(gi))),
        .sync_out  (raw[gi]),
        .pending   (pending[gi]),
        .missed    (missed_v[gi])
      );
    end
  endgenerate

  // priority encoder: lowest set index of PENDING & MASK wins
  always_comb begin
    act_valid = 1'b0;
    act_idx   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (pm[i]) begin
        act_valid = 1'b1;
        act_idx   = 4'(i);
      end
  end

  // MASK and EDGE_MODE software registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mask      <= '0;
      edge_mode <= EDGE_RESET[NUM_IRQ-1:0];
    end else if (wr) begin
      if (address == ADDR_MASK) mask      <= writedata[NUM_IRQ-1:0];
      if (address == ADDR_EDGE) edge_mode <= writedata[NUM_IRQ-1:0];
    end

  // MISSED: +1 per cycle with any overrun, saturating; any write clears and wins
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)                             missed_cnt <= '0;
    else if (wr && address == ADDR_MISSED)    missed_cnt <= '0;
    else if (|missed_v && missed_cnt != '1)   missed_cnt <= missed_cnt + 16'd1;

  // read mux; unused high bits read 0 through zero-extension
  always_comb begin
    rd_active                   = '0;
    rd_active[ACTIVE_VALID_BIT] = act_valid;
    rd_active[3:0]              = act_idx;
    case (address)
      ADDR_PENDING: rd_mux = 16'(pending);
      ADDR_MASK:    rd_mux = 16'(mask);
      ADDR_EDGE:    rd_mux = 16'(edge_mode);
      ADDR_RAW:     rd_mux = 16'(raw);
      ADDR_ACTIVE:  rd_mux = rd_active;
      ADDR_MISSED:  rd_mux = missed_cnt;
      default:      rd_mux = '0;
    endcase
  end

  // registered readdata and combined irq
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_mux;
      irq      <= |pm;
    end

endmodule

// File: tb/tb_game_irq_ctrl.sv
// Directed bench for game_irq_ctrl (NUM_IRQ = 8, SYNC_EN = 1).
module tb_game_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  irq_in;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;

  int passed = 0;
  int total  = 0;

  game_irq_ctrl #(.NUM_IRQ(8), .SYNC_EN(1'b1), .EDGE_RESET(16'hFFFF)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .irq_in     (irq_in),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  task automatic do_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
    chk(tag, readdata, exp);
  endtask

  task automatic pulse(input logic [7:0] v);
    @(negedge clk); irq_in = v;
    @(negedge clk); irq_in = '0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; irq_in = '0; address = '0;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // reset state
    chk("rst_irq", {15'd0, irq}, 16'h0000);
    rd_chk("rst_pending", 3'd0, 16'h0000);
    rd_chk("rst_mask",    3'd1, 16'h0000);
    rd_chk("rst_edge",    3'd2, 16'h00FF);
    rd_chk("rst_raw",     3'd3, 16'h0000);
    rd_chk("rst_active",  3'd4, 16'h0000);
    rd_chk("rst_missed",  3'd6, 16'h0000);

    // single pulse on source 0, latency through synchronizer
    do_write(3'd1, 16'h0001);
    @(negedge clk); irq_in = 8'h01;
    @(negedge clk); irq_in = '0; chk("lat_k",  {15'd0, irq}, 16'h0000);
    @(negedge clk);              chk("lat_k1", {15'd0, irq}, 16'h0000);
    @(negedge clk);              chk("lat_k2", {15'd0, irq}, 16'h0000);
    @(negedge clk);              chk("lat_k3", {15'd0, irq}, 16'h0001);
    rd_chk("p0_pending", 3'd0, 16'h0001);
    rd_chk("p0_active",  3'd4, 16'h8000);
    do_write(3'd4, 16'h0000);
    chk("ack_irq_hold", {15'd0, irq}, 16'h0001);
    @(negedge clk);
    chk("ack_irq_low", {15'd0, irq}, 16'h0000);
    rd_chk("ack_pending", 3'd0, 16'h0000);

    // priority among sources 2 and 5
    pulse(8'h24);
    do_write(3'd1, 16'h0024);
    rd_chk("prio_active_2", 3'd4, 16'h8002);
    do_write(3'd0, 16'h0004);
    rd_chk("prio_active_5", 3'd4, 16'h8005);
    rd_chk("prio_pending",  3'd0, 16'h0020);
    chk("prio_irq", {15'd0, irq}, 16'h0001);
    do_write(3'd4, 16'h0000);
    rd_chk("prio_cleared", 3'd0, 16'h0000);

    // level mode on source 0
    do_write(3'd2, 16'h00FE);
    @(negedge clk); irq_in = 8'h01;
    repeat (4) @(negedge clk);
    rd_chk("lvl_raw",     3'd3, 16'h0001);
    rd_chk("lvl_pending", 3'd0, 16'h0001);
    do_write(3'd0, 16'h0001);
    rd_chk("lvl_w1c_noeff", 3'd0, 16'h0001);
    @(negedge clk); irq_in = '0;
    repeat (4) @(negedge clk);
    rd_chk("lvl_drop", 3'd0, 16'h0000);
    do_write(3'd2, 16'h00FF);

    // overrun on source 3
    pulse(8'h08);
    rd_chk("ovr_pending", 3'd0, 16'h0008);
    rd_chk("ovr_missed0", 3'd6, 16'h0000);
    pulse(8'h08);
    rd_chk("ovr_missed1", 3'd6, 16'h0001);
    // edge lands in the same cycle as W1C of bit 3: set wins, no miss
    @(negedge clk); irq_in = 8'h08;
    @(negedge clk); irq_in = '0;
    @(negedge clk);
    address = 3'd0; writedata = 16'h0008; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    repeat (2) @(negedge clk);
    rd_chk("race_pending", 3'd0, 16'h0008);
    rd_chk("race_missed",  3'd6, 16'h0001);
    do_write(3'd6, 16'h1234);
    rd_chk("missed_clr", 3'd6, 16'h0000);
    do_write(3'd0, 16'h0008);
    rd_chk("w1c3", 3'd0, 16'h0000);

    // FORCE with mask off, then unmask
    do_write(3'd1, 16'h0000);
    do_write(3'd5, 16'h0080);
    rd_chk("frc_pending", 3'd0, 16'h0080);
    rd_chk("frc_readback", 3'd5, 16'h0000);
    rd_chk("addr7", 3'd7, 16'h0000);
    chk("frc_irq_masked", {15'd0, irq}, 16'h0000);
    do_write(3'd1, 16'h0080);
    chk("unmask_irq_lag", {15'd0, irq}, 16'h0000);
    @(negedge clk);
    chk("unmask_irq", {15'd0, irq}, 16'h0001);

    // asynchronous reset mid-run
    address = 3'd0;
    @(negedge clk);
    chk("pre_rst_rd", readdata, 16'h0080);
    #2 reset_n = 1'b0;
    #1;
    chk("async_irq", {15'd0, irq}, 16'h0000);
    chk("async_rd",  readdata, 16'h0000);
    @(negedge clk); reset_n = 1'b1;
    rd_chk("post_pending", 3'd0, 16'h0000);
    rd_chk("post_mask",    3'd1, 16'h0000);
    rd_chk("post_edge",    3'd2, 16'h00FF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
